// File: rtl/rs_encode_sched.sv
// RS(15,9) GF(16) encode scheduler: round-robin over two message sources, symbol-serial parity LFSR.
// Define RS_SCHED_CNT_EN to add per-source saturating codeword counters (cnt0, cnt1).
module rs_encode_sched #(
  parameter int NSYM = 9,
  parameter int NPAR = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  input  logic [4*NSYM-1:0]            req0_msg,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [4*NSYM-1:0]            req1_msg,
  output logic                         req1_ready,
  output logic                         cw_valid,
  output logic [4*(NSYM+NPAR)-1:0]     cw_data,
  output logic                         cw_src,
  input  logic                         cw_ready,
  output logic                         busy
`ifdef RS_SCHED_CNT_EN
  ,
  output logic [15:0]                  cnt0,
  output logic [15:0]                  cnt1
`endif
);

  // Generator feedback constants g5..g0 packed with g0 in the low nibble.
  localparam logic [4*NPAR-1:0] GEN = 24'h7_9_3_C_A_C;

  typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

  state_t                state;
  logic [4*NSYM-1:0]     msg;
  logic                  src;
  logic [4*NPAR-1:0]     lfsr;
  logic [4*NPAR-1:0]     lfsr_next;
  logic [3:0]            cnt;
  logic [3:0]            sym;
  logic [3:0]            fb;
  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // On a tie the source not granted last wins; last_grant resets to 1 so source 0 wins first.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = ~rst & (state == IDLE) & grant0;
    req1_ready = ~rst & (state == IDLE) & grant1;
  end

  always_comb begin
    sym = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (cnt == 4'(i)) sym = msg[4*i +: 4];
    end
    fb = lfsr[4*NPAR-1 -: 4] ^ sym;
    lfsr_next = '0;
    lfsr_next[3:0] = gf_mul(fb, GEN[3:0]);
    for (int k = 1; k < NPAR; k++) begin
      lfsr_next[4*k +: 4] = lfsr[4*(k-1) +: 4] ^ gf_mul(fb, GEN[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      msg        <= '0;
      src        <= 1'b0;
      lfsr       <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      cw_valid   <= 1'b0;
      cw_data    <= '0;
      cw_src     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            msg   <= req1_ready ? req1_msg : req0_msg;
            src   <= req1_ready;
            lfsr  <= '0;
            cnt   <= 4'(NSYM-1);
            busy  <= 1'b1;
            state <= ENCODE;
          end
        end
        ENCODE: begin
          lfsr <= lfsr_next;
          // The step with cnt==0 consumes message symbol 0 and completes the parity.
          if (cnt == 4'd0) begin
            cw_data  <= {msg, lfsr_next};
            cw_src   <= src;
            cw_valid <= 1'b1;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cw_ready) begin
            cw_valid   <= 1'b0;
            last_grant <= src;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RS_SCHED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state == HOLD && cw_ready) begin
      if (!src && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (src && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_encode_sched.sv
// Bench for rs_encode_sched: directed and random messages checked against a polynomial-division RS model.
// Also exercises the RS_SCHED_CNT_EN counters when that macro is defined.
module tb_rs_encode_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [35:0] req0_msg = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [35:0] req1_msg = '0;
  logic        req1_ready;
  logic        cw_valid;
  logic [59:0] cw_data;
  logic        cw_src;
  logic        cw_ready = 1'b0;
  logic        busy;
`ifdef RS_SCHED_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  int          exp_cnt0 = 0;
  int          exp_cnt1 = 0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int gexp [0:14];
  int glog [0:15];
  int gpow [0:5] = '{6, 9, 6, 4, 14, 10};

  rs_encode_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_msg   (req0_msg),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_msg   (req1_msg),
    .req1_ready (req1_ready),
    .cw_valid   (cw_valid),
    .cw_data    (cw_data),
    .cw_src     (cw_src),
    .cw_ready   (cw_ready),
    .busy       (busy)
`ifdef RS_SCHED_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  // Parity is the remainder of m(x)*x^6 divided by the monic generator polynomial.
  function automatic logic [59:0] ref_codeword(input logic [35:0] m);
    int c [0:14];
    int coef;
    logic [59:0] r;
    for (int i = 0; i < 15; i++) c[i] = 0;
    for (int i = 0; i < 9; i++) c[i+6] = int'(m[4*i +: 4]);
    for (int d = 14; d >= 6; d--) begin
      coef = c[d];
      c[d] = 0;
      for (int k = 0; k < 6; k++) c[d-6+k] = c[d-6+k] ^ gmul(coef, gexp[gpow[k]]);
    end
    r = '0;
    r[59:24] = m;
    for (int j = 0; j < 6; j++) r[4*j +: 4] = 4'(c[j]);
    return r;
  endfunction

  function automatic logic [35:0] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cw_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef RS_SCHED_CNT_EN
    exp_cnt0 = 0;
    exp_cnt1 = 0;
`endif
  endtask

  // Holds the request until granted; returns at the negedge after the handshake edge.
  task automatic present(input int src, input logic [35:0] m);
    bit ok = 1'b0;
    if (src == 0) begin req0_valid = 1'b1; req0_msg = m; end
    else begin req1_valid = 1'b1; req1_msg = m; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      ok = (src == 0) ? req0_ready : req1_ready;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("grant", 64'(ok), 64'd1);
  endtask

  task automatic expect_cw(input int src, input logic [35:0] m);
    int n = 0;
    while (!cw_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd9);
    check("cw_data", 64'(cw_data), 64'(ref_codeword(m)));
    check("cw_src", 64'(cw_src), 64'(src));
  endtask

  task automatic retire(input int src);
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    check("retire_valid", 64'(cw_valid), 64'd0);
    check("retire_busy", 64'(busy), 64'd0);
`ifdef RS_SCHED_CNT_EN
    if (src == 0) exp_cnt0++; else exp_cnt1++;
`endif
  endtask

  initial begin
    logic [35:0] m;
    logic [35:0] msg0;
    logic [35:0] msg1;
    logic [59:0] hold_cw;
    int          src;
    int          next_grant;
    int          last_cw;
    int          ncw;
    int          es;
    logic [35:0] em;
    bit          g0;
    bit          g1;
    int          exp_src [$];
    logic [35:0] exp_msg [$];

    gexp[0] = 1;
    glog[0] = 0;
    glog[1] = 0;
    for (int i = 1; i < 15; i++) begin
      int v;
      v = gexp[i-1] << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
      gexp[i] = v;
      glog[v] = i;
    end

    $display("[TB] reset and ready gating");
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cw_valid", 64'(cw_valid), 64'd0);
    check("rst_cw_data", 64'(cw_data), 64'd0);
    check("rst_cw_src", 64'(cw_src), 64'd0);

    $display("[TB] directed vectors");
    present(0, 36'h000000001);
    expect_cw(0, 36'h000000001);
    check("lit_msg1", 64'(cw_data), 64'h000000001793CAC);
    retire(0);
    present(1, 36'h000000002);
    expect_cw(1, 36'h000000002);
    check("lit_msg2", 64'(cw_data), 64'h000000002E16B7B);
    retire(1);
    present(0, 36'h000000003);
    expect_cw(0, 36'h000000003);
    check("lit_msg3", 64'(cw_data), 64'h0000000039857D7);
    retire(0);

    $display("[TB] round-robin with both sources busy");
    do_reset();
    cw_ready = 1'b1;
    msg0 = '0;
    msg1 = rand36();
    req0_msg = msg0;
    req1_msg = msg1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    next_grant = 0;
    last_cw = -1;
    ncw = 0;
    for (int cyc = 0; cyc < 77; cyc++) begin
      if (cw_valid) begin
        if (exp_msg.size() > 0) begin
          es = exp_src.pop_front();
          em = exp_msg.pop_front();
          check("rr_cw_data", 64'(cw_data), 64'(ref_codeword(em)));
          check("rr_cw_src", 64'(cw_src), 64'(es));
`ifdef RS_SCHED_CNT_EN
          if (es == 0) exp_cnt0++; else exp_cnt1++;
`endif
        end else begin
          check("rr_unexpected_cw", 64'd1, 64'd0);
        end
        if (ncw == 0) check("rr_zero_msg", 64'(cw_data), 64'd0);
        if (last_cw >= 0) check("rr_spacing", 64'(cyc - last_cw), 64'd11);
        last_cw = cyc;
        ncw++;
      end
      #1;
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 | g1) begin
        check("rr_one_hot", 64'(g0 & g1), 64'd0);
        check("rr_order", 64'(g1), 64'(next_grant));
        exp_src.push_back(g1 ? 1 : 0);
        exp_msg.push_back(g1 ? req1_msg : req0_msg);
        next_grant = 1 - next_grant;
      end
      @(negedge clk);
      if (g0) req0_msg = rand36();
      if (g1) req1_msg = rand36();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cw_ready = 1'b0;
    check("rr_count", 64'(ncw), 64'd7);
    check("rr_leftover", 64'(exp_msg.size()), 64'd0);

    $display("[TB] sink backpressure in HOLD");
    m = rand36();
    present(1, m);
    expect_cw(1, m);
    hold_cw = ref_codeword(m);
    req0_valid = 1'b1;
    req0_msg = rand36();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 64'(cw_valid), 64'd1);
      check("hold_data", 64'(cw_data), 64'(hold_cw));
      check("hold_ready0", 64'(req0_ready), 64'd0);
      check("hold_ready1", 64'(req1_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    req0_valid = 1'b0;
    retire(1);
    req0_valid = 1'b1;
    #1;
    check("hold_idle_ready0", 64'(req0_ready), 64'd1);
    req0_valid = 1'b0;

    $display("[TB] reset abort mid-encode");
    m = rand36();
    present(0, m);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef RS_SCHED_CNT_EN
    exp_cnt0 = 0;
    exp_cnt1 = 0;
`endif
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cw_valid", 64'(cw_valid), 64'd0);
    check("abort_cw_data", 64'(cw_data), 64'd0);
    present(0, m);
    expect_cw(0, m);
    retire(0);

    $display("[TB] reset coinciding with a request");
    rst = 1'b1;
    req1_valid = 1'b1;
    req1_msg = rand36();
    #1;
    check("rst_hs_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req1_valid = 1'b0;
    check("rst_hs_busy", 64'(busy), 64'd0);
`ifdef RS_SCHED_CNT_EN
    exp_cnt0 = 0;
    exp_cnt1 = 0;
`endif

    $display("[TB] random messages");
    for (int i = 0; i < 8; i++) begin
      src = int'($urandom_range(0, 1));
      m = rand36();
      present(src, m);
      expect_cw(src, m);
      retire(src);
    end

`ifdef RS_SCHED_CNT_EN
    check("cnt0", 64'(cnt0), 64'(exp_cnt0));
    check("cnt1", 64'(cnt1), 64'(exp_cnt1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
